// File: rtl/fp_align_add.sv
// fp_align_add: front end of the single-precision adder.
//   Masks sign/exponent/mantissa (hidden bit restored), aligns the smaller
//   operand to the larger exponent capturing guard/round/sticky, then does a
//   signed-magnitude 24-bit add/subtract. All outputs registered, latency 1.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid, a, b      operand strobe and IEEE-754 single operands
//   out_valid           registered result strobe
//   sign_*/exponent_*   masked fields of each operand
//   aligned_mantissa_*  24-bit mantissas after alignment
//   exponent_out        common (larger) exponent, ties pick a
//   aligned_result      low 24 bits of the sum/difference, carry_out = bit 24
//   aligned_sign        sign of the larger aligned mantissa, ties pick a
//   guard/round/sticky  bits shifted out of the smaller operand
// Optional: define FPA_ZERO_FLAG_EN to add result_zero ({carry,result} == 0).
module fp_align_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic        sign_a,
    output logic        sign_b,
    output logic [7:0]  exponent_a,
    output logic [7:0]  exponent_b,
    output logic [23:0] aligned_mantissa_a,
    output logic [23:0] aligned_mantissa_b,
    output logic [7:0]  exponent_out,
    output logic [23:0] aligned_result,
    output logic        carry_out,
    output logic        aligned_sign,
    output logic        guard_bit,
    output logic        round_bit,
    output logic        sticky_bit
`ifdef FPA_ZERO_FLAG_EN
    ,
    output logic        result_zero
`endif
);

    logic        sA, sB;
    logic [7:0]  eA, eB;
    logic [23:0] mA, mB;

    assign sA = a[31];
    assign sB = b[31];
    assign eA = a[30:23];
    assign eB = b[30:23];
    assign mA = {|eA, a[22:0]};
    assign mB = {|eB, b[22:0]};

    // a is the reference operand on equal exponents, so b never shifts then.
    logic        aBig;
    logic [7:0]  expDiff;
    logic [23:0] mSmall;

    assign aBig    = (eA >= eB);
    assign expDiff = aBig ? (eA - eB) : (eB - eA);
    assign mSmall  = aBig ? mB : mA;

    // Any shift of 26 or more parks the whole mantissa below the round bit,
    // so clamping there keeps the sticky OR exact with a 50-bit window.
    logic [4:0]  shAmt;
    logic [49:0] shifted;
    logic [23:0] alnSmall, alnA, alnB;
    logic        gBit, rBit, sBit;

    assign shAmt    = (expDiff > 8'd26) ? 5'd26 : expDiff[4:0];
    assign shifted  = {mSmall, 26'b0} >> shAmt;
    assign alnSmall = shifted[49:26];
    assign gBit     = shifted[25];
    assign rBit     = shifted[24];
    assign sBit     = |shifted[23:0];
    assign alnA     = aBig ? mA : alnSmall;
    assign alnB     = aBig ? alnSmall : mB;

    // Signed-magnitude ALU; magnitude compare picks operand order and sign.
    logic        bBigger;
    logic [24:0] sum;
    logic        resSign;

    assign bBigger = (alnB > alnA);
    assign resSign = bBigger ? sB : sA;

    always_comb begin
        sum = '0;
        if (sA == sB)
            sum = {1'b0, alnA} + {1'b0, alnB};
        else if (bBigger)
            sum = {1'b0, alnB - alnA};
        else
            sum = {1'b0, alnA - alnB};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            sign_a             <= 1'b0;
            sign_b             <= 1'b0;
            exponent_a         <= '0;
            exponent_b         <= '0;
            aligned_mantissa_a <= '0;
            aligned_mantissa_b <= '0;
            exponent_out       <= '0;
            aligned_result     <= '0;
            carry_out          <= 1'b0;
            aligned_sign       <= 1'b0;
            guard_bit          <= 1'b0;
            round_bit          <= 1'b0;
            sticky_bit         <= 1'b0;
`ifdef FPA_ZERO_FLAG_EN
            result_zero        <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign_a             <= sA;
                sign_b             <= sB;
                exponent_a         <= eA;
                exponent_b         <= eB;
                aligned_mantissa_a <= alnA;
                aligned_mantissa_b <= alnB;
                exponent_out       <= aBig ? eA : eB;
                aligned_result     <= sum[23:0];
                carry_out          <= sum[24];
                aligned_sign       <= resSign;
                guard_bit          <= gBit;
                round_bit          <= rBit;
                sticky_bit         <= sBit;
`ifdef FPA_ZERO_FLAG_EN
                result_zero        <= (sum == 25'd0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_align_add.sv
module tb_fp_align_add;

    typedef struct packed {
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic [7:0]  eo;
        logic [23:0] res;
        logic        carry, sign, g, r, s;
`ifdef FPA_ZERO_FLAG_EN
        logic        zero;
`endif
    } res_t;

    logic        clk = 0, rst = 1, in_valid = 0;
    logic [31:0] a = 0, b = 0;
    logic        out_valid, sign_a, sign_b, carry_out, aligned_sign;
    logic        guard_bit, round_bit, sticky_bit;
    logic [7:0]  exponent_a, exponent_b, exponent_out;
    logic [23:0] aligned_mantissa_a, aligned_mantissa_b, aligned_result;
`ifdef FPA_ZERO_FLAG_EN
    logic        result_zero;
`endif

    fp_align_add dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .sign_a(sign_a), .sign_b(sign_b),
        .exponent_a(exponent_a), .exponent_b(exponent_b),
        .aligned_mantissa_a(aligned_mantissa_a), .aligned_mantissa_b(aligned_mantissa_b),
        .exponent_out(exponent_out), .aligned_result(aligned_result),
        .carry_out(carry_out), .aligned_sign(aligned_sign),
        .guard_bit(guard_bit), .round_bit(round_bit), .sticky_bit(sticky_bit)
`ifdef FPA_ZERO_FLAG_EN
        , .result_zero(result_zero)
`endif
    );

    always #5 clk = ~clk;

    res_t act;
    always_comb begin
        act       = '0;
        act.sa    = sign_a;
        act.sb    = sign_b;
        act.ea    = exponent_a;
        act.eb    = exponent_b;
        act.ma    = aligned_mantissa_a;
        act.mb    = aligned_mantissa_b;
        act.eo    = exponent_out;
        act.res   = aligned_result;
        act.carry = carry_out;
        act.sign  = aligned_sign;
        act.g     = guard_bit;
        act.r     = round_bit;
        act.s     = sticky_bit;
`ifdef FPA_ZERO_FLAG_EN
        act.zero  = result_zero;
`endif
    end

    int   checks = 0, errors = 0;
    res_t sb[$];
    res_t lastExp;

    // Reference: the shifted-out stream is walked bit by bit on integers.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t e;
        int ea, eb, ma, mb, d, sm, big, alnS, sum, A, B;
        e = '0;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = (ea != 0 ? 32'h800000 : 0) + int'(x[22:0]);
        mb = (eb != 0 ? 32'h800000 : 0) + int'(y[22:0]);
        if (ea >= eb) begin d = ea - eb; big = ma; sm = mb; e.eo = 8'(ea); end
        else          begin d = eb - ea; big = mb; sm = ma; e.eo = 8'(eb); end
        alnS = (d >= 24) ? 0 : (sm >> d);
        e.g = (d >= 1 && d - 1 < 24) ? 1'((sm >> (d - 1)) & 1) : 1'b0;
        e.r = (d >= 2 && d - 2 < 24) ? 1'((sm >> (d - 2)) & 1) : 1'b0;
        for (int i = 0; i < 24; i++)
            if (i < d - 2 && ((sm >> i) & 1) == 1) e.s = 1'b1;
        if (ea >= eb) begin A = big; B = alnS; end
        else          begin A = alnS; B = big; end
        e.sa = x[31]; e.sb = y[31];
        e.ea = 8'(ea); e.eb = 8'(eb);
        e.ma = 24'(A); e.mb = 24'(B);
        if (x[31] == y[31]) sum = A + B;
        else sum = (A > B) ? A - B : B - A;
        e.res   = 24'(sum);
        e.carry = 1'(sum >> 24);
        e.sign  = (B > A) ? y[31] : x[31];
`ifdef FPA_ZERO_FLAG_EN
        e.zero  = (sum == 0);
`endif
        return e;
    endfunction

    // Monitor: every presented result is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, queue empty", act);
            end else begin
                res_t e;
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL sb_result: got %h expected %h", act, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        a = x; b = y; in_valid = 1;
        lastExp = model(x, y);
        sb.push_back(lastExp);
        @(posedge clk); #1;
    endtask

    // Single transaction plus literal checks of the key fields.
    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic [7:0] eo,
                            input logic [23:0] res, input logic c, input logic sg,
                            input logic [2:0] grs);
        issue(x, y);
        in_valid = 0;
        @(negedge clk);
        check("dir_valid", 128'(out_valid), 128'(1));
        check("dir_fields", {eo, res, c, sg, grs},
              {exponent_out, aligned_result, carry_out, aligned_sign, guard_bit, round_bit, sticky_bit});
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset_out", 128'(act), 128'(0));
        check("reset_valid", 128'(out_valid), 128'(0));
        @(negedge clk); rst = 0;
        repeat (2) @(posedge clk); #1;
        check("post_reset_out", 128'(act), 128'(0));
        check("post_reset_valid", 128'(out_valid), 128'(0));

        directed(32'h3F800000, 32'h40000000, 8'h80, 24'hC00000, 0, 0, 3'b000);
        directed(32'h3F800000, 32'h3F800000, 8'h7F, 24'h000000, 1, 0, 3'b000);
        directed(32'h3F800000, 32'hBF800000, 8'h7F, 24'h000000, 0, 0, 3'b000);
        directed(32'hBF800000, 32'h3F800000, 8'h7F, 24'h000000, 0, 1, 3'b000);
        directed(32'h40000000, 32'h3F800001, 8'h80, 24'hC00000, 0, 0, 3'b100);
        directed(32'h4B000000, 32'h3F800000, 8'h96, 24'h800001, 0, 0, 3'b000);
        directed(32'h4E800000, 32'h3F800001, 8'h9D, 24'h800000, 0, 0, 3'b001);
        directed(32'h4B800000, 32'h3F800000, 8'h97, 24'h800000, 0, 0, 3'b100);
        directed(32'h40000000, 32'hBF800000, 8'h80, 24'h400000, 0, 0, 3'b000);

        // Hold: data keeps the last result with out_valid low.
        @(negedge clk);
        check("hold_valid", 128'(out_valid), 128'(0));
        check("hold_data", 128'(act), 128'(lastExp));
        @(posedge clk); #1;

        // Randomized back-to-back stream, biased toward small exponent gaps.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] x, y;
            int ex, ey;
            x  = $urandom;
            ex = int'(x[30:23]);
            case ($urandom_range(0, 3))
                0: ey = int'($urandom_range(0, 255));
                1: ey = ex;
                default: begin
                    ey = ex + int'($urandom_range(0, 60)) - 30;
                    if (ey < 0) ey = 0;
                    if (ey > 255) ey = 255;
                end
            endcase
            y = {1'($urandom), 8'(ey), 23'($urandom)};
            if ($urandom_range(0, 15) == 0) y[22:0] = x[22:0];
            issue(x, y);
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
        end
        in_valid = 0;

        // Bounded drain of the scoreboard.
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("sb_drained", 128'(sb.size()), 128'(0));

        // Mid-stream asynchronous reset between edges.
        issue(32'h40400000, 32'h3F000000);
        in_valid = 0;
        #1 rst = 1;
        #1;
        check("async_rst_out", 128'(act), 128'(0));
        check("async_rst_valid", 128'(out_valid), 128'(0));
        sb.delete();
        @(negedge clk); rst = 0;
        repeat (3) @(posedge clk); #1;
        check("rst_release_out", 128'(act), 128'(0));
        check("rst_release_valid", 128'(out_valid), 128'(0));

        // Stream resumes cleanly after reset.
        directed(32'h3F800000, 32'h40000000, 8'h80, 24'hC00000, 0, 0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Front end of the single-precision IEEE-754 adder. Performs three steps in one pass:
  - field masking (sign, exponent, mantissa with hidden bit);
  - exponent alignment with guard/round/sticky capture;
  - signed-magnitude mantissa add/subtract.
- All outputs are registered, one cycle after input acceptance.
- Output feeds the normalization/rounding stage.

Parameters:
- None. Format is fixed: 1-bit sign, 8-bit exponent, 23-bit fraction.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a and b are sampled on a clk edge while high.
- a  input  32  operand A, IEEE single.
- b  input  32  operand B, IEEE single.
- out_valid  output  1  registered outputs hold a new result.
- sign_a, sign_b  output  1 each  masked sign bits.
- exponent_a, exponent_b  output  8 each  masked exponents.
- aligned_mantissa_a, aligned_mantissa_b  output  24 each  mantissas after alignment.
- exponent_out  output  8  common (larger) exponent.
- aligned_result  output  24  low 24 bits of the mantissa sum/difference.
- carry_out  output  1  bit 24 of the sum.
- aligned_sign  output  1  result sign.
- guard_bit, round_bit, sticky_bit  output  1 each  bits shifted out of the smaller operand.

Behaviour:
- Reset: on rst high, every output clears to 0 asynchronously, including out_valid. Outputs stay 0 until the first accepted input after rst falls.
- Timing:
  - Edge with in_valid=1: all outputs update from a/b; out_valid=1 next cycle (latency 1).
  - Edge with in_valid=0: out_valid=0; data outputs hold their last values.
  - Back-to-back in_valid gives one result per cycle.
- Mask:
  - sign = bit31, exponent = bits30:23.
  - Mantissa = {hidden, bits22:0}; hidden = 1 when exponent != 0, else 0.
- Alignment:
  - exponent_out = max(exponent_a, exponent_b); on equal exponents it is exponent_a.
  - d = absolute exponent difference. The smaller-exponent operand's 24-bit mantissa is shifted right by d; the other passes unshifted. Equal exponents: no shift.
  - Shifted-out bits form a stream, most significant first: guard = 1st bit, round = 2nd bit, sticky = OR of all remaining bits.
  - d = 0: guard, round and sticky are all 0.
  - d >= 24: aligned mantissa = 0.
  - d >= 26: guard = 0 and round = 0 except as the stream naturally provides. d = 24 gives guard = hidden bit; sticky always covers every bit beyond round. No wrap or truncation of d (full 0..255 range).
- ALU (operates on the 24-bit aligned mantissas only; guard/round/sticky are passed through unchanged):
  - sign_a == sign_b: {carry_out, aligned_result} = A + B, 25-bit.
  - Signs differ: larger minus smaller aligned mantissa; carry_out = 0.
  - aligned_sign: sign of the operand with the larger aligned mantissa. On equal aligned mantissas it is sign_a, so 1.0 + (-1.0) gives sign 0 and -1.0 + 1.0 gives sign 1.
- Special values: NaN, Inf and denormals are not special-cased; they follow the same masking and arithmetic rules.

Optional Feature:
- Macro: FPA_ZERO_FLAG_EN.
- Defined: adds output port result_zero (1 bit, registered with the other outputs, reset 0). result_zero = 1 when {carry_out, aligned_result} == 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- a=3F800000, b=40000000 -> exponent_out=80, aligned_mantissa_a=400000, aligned_mantissa_b=800000, aligned_result=C00000, carry_out=0, aligned_sign=0, guard/round/sticky=0, out_valid one cycle after in_valid.
- a=3F800000, b=3F800000 -> carry_out=1, aligned_result=000000, exponent_out=7F, aligned_sign=0.
- a=3F800000, b=BF800000 -> aligned_result=0, carry_out=0, aligned_sign=0 (result_zero=1 with FPA_ZERO_FLAG_EN). Swapped operands -> aligned_sign=1.
- a=40000000, b=3F800001 -> aligned_mantissa_b=400000, guard=1, round=0, sticky=0, aligned_result=C00000.
- Shift limits:
  - a=4B000000, b=3F800000 (d=23) -> aligned_mantissa_b=000001, aligned_result=800001.
  - a=4E800000, b=3F800001 (d=30) -> aligned_mantissa_b=0, guard=0, round=0, sticky=1, aligned_result=800000.
- Reset and hold:
  - Assert rst mid-stream between clk edges -> all outputs 0 immediately.
  - After release with in_valid=0 -> outputs stay 0 and out_valid=0.
  - After a valid result, drop in_valid -> data holds, out_valid=0.
